// File: rtl/tc_pkg.sv
// Shared types and constants for the tc_array timer block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } tc_state_e;

  localparam logic [1:0] MODE_ONESHOT     = 2'd0;
  localparam logic [1:0] MODE_RELOAD      = 2'd1;
  localparam logic [1:0] MODE_GATED       = 2'd2;
  localparam logic [1:0] MODE_ONESHOT_ALT = 2'd3;

  localparam logic [1:0] OFS_CTRL   = 2'd0;
  localparam logic [1:0] OFS_PRESET = 2'd1;
  localparam logic [1:0] OFS_COUNT  = 2'd2;
  localparam logic [1:0] OFS_STATUS = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_PSC_LO  = 8;
  localparam int CTRL_PSC_HI  = 15;

  // MODE 1 and 2 restart the count after expiry; 0 and 3 stop.
  function automatic logic mode_reloads(input logic [1:0] mode);
    return (mode == MODE_RELOAD) || (mode == MODE_GATED);
  endfunction

endpackage

// File: rtl/tc_channel.sv
// One down-counting timer channel: CTRL/PRESET/COUNT/PEND registers and its FSM.
// Latency: EN write to PEND set = PRESET+2 edges (PRESET=0 counts as 1); read-back is combinational.
// Backpressure: none, register writes are always accepted. Optional prescaler: TC_PRESCALE_EN.
module tc_channel
  import tc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_ctrl,
  input  logic        wr_preset,
  input  logic        wr_status,
  input  logic [31:0] wdata,
  input  logic        gate,
  input  logic [1:0]  rd_ofs,
  output logic [31:0] rdata,
  output logic        irq
);

  tc_state_e        state, state_nxt;
  logic             en, im, pend;
  logic [1:0]       mode;
  logic [CNT_W-1:0] preset, count;
  logic             en_wr, count_le1, tick_q, tick, reload;
  logic             load_cnt, dec_cnt, set_pend, clr_en;

  // EN as it will be after this edge; lets a fresh enable leave IDLE immediately.
  assign en_wr     = wr_ctrl ? wdata[CTRL_EN] : en;
  assign count_le1 = (count <= CNT_W'(1));
  assign reload    = mode_reloads(mode);
  // Gated mode only advances when the external gate is high.
  assign tick_q    = (mode == MODE_GATED) ? gate : 1'b1;

`ifdef TC_PRESCALE_EN
  logic [7:0] psc, pcnt;
  assign tick = tick_q && (pcnt == psc);
`else
  assign tick = tick_q;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: one transition per edge.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (en_wr) state_nxt = LOAD;
      LOAD: state_nxt = CNT;
      CNT: begin
        if (!en)                    state_nxt = IDLE;
        else if (tick && count_le1) state_nxt = INT;
      end
      INT:  state_nxt = reload ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath strobes decoded from the current state.
  always_comb begin
    load_cnt = (state == LOAD);
    dec_cnt  = (state == CNT) && en && tick;
    set_pend = (state == INT);
    clr_en   = (state == INT) && !reload;
  end

  // Register file and counter; PEND set beats any same-cycle clear, written EN beats auto-clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      en     <= 1'b0;
      mode   <= MODE_ONESHOT;
      im     <= 1'b0;
      preset <= '0;
      count  <= '0;
      pend   <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en   <= wdata[CTRL_EN];
        mode <= wdata[CTRL_MODE_HI:CTRL_MODE_LO];
        im   <= wdata[CTRL_IM];
      end else if (clr_en) begin
        en <= 1'b0;
      end
      if (wr_preset) preset <= wdata[CNT_W-1:0];
      if (load_cnt)     count <= preset;
      else if (dec_cnt) count <= count_le1 ? '0 : count - CNT_W'(1);
      if (set_pend)                                       pend <= 1'b1;
      else if (wr_ctrl || (wr_status && wdata[0]))        pend <= 1'b0;
    end
  end

`ifdef TC_PRESCALE_EN
  // Prescaler: one tick per PSC+1 qualifying cycles, restarted whenever the channel reloads or idles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      psc  <= '0;
      pcnt <= '0;
    end else begin
      if (wr_ctrl) psc <= wdata[CTRL_PSC_HI:CTRL_PSC_LO];
      if (state == IDLE || state == LOAD) pcnt <= '0;
      else if (state == CNT && en && tick_q) pcnt <= (pcnt == psc) ? '0 : pcnt + 8'd1;
    end
  end
`endif

  // Read-back mux, unused bits zero.
  always_comb begin
    rdata = '0;
    unique case (rd_ofs)
      OFS_CTRL: begin
        rdata[CTRL_EN]                   = en;
        rdata[CTRL_MODE_HI:CTRL_MODE_LO] = mode;
        rdata[CTRL_IM]                   = im;
`ifdef TC_PRESCALE_EN
        rdata[CTRL_PSC_HI:CTRL_PSC_LO]   = psc;
`endif
      end
      OFS_PRESET: rdata[CNT_W-1:0] = preset;
      OFS_COUNT:  rdata[CNT_W-1:0] = count;
      OFS_STATUS: rdata[0]         = pend;
      default:    rdata            = '0;
    endcase
  end

  assign irq = pend & im;

endmodule

// File: rtl/tc_array.sv
// NCH-channel down-counting timer array behind one word-addressed register port, with irq summary.
// Latency: combinational read data; channel timing as in tc_channel.
// Backpressure: none, writes always accepted. Optional prescaler: TC_PRESCALE_EN.
module tc_array
  import tc_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  input  logic [NCH-1:0]    gate,
  output logic [NCH-1:0]    irq,
  output logic              irq_any
);

  localparam int SUM_WORD = NCH * 4;

  logic [ADDR_W-3:0] ch_field;
  logic [1:0]        ofs;
  logic [NCH-1:0]    hit;
  logic [31:0]       ch_rdata [NCH];

  assign ch_field = addr[ADDR_W-1:2];
  assign ofs      = addr[1:0];

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign hit[c] = (ch_field == (ADDR_W-2)'(c));

    tc_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .wr_ctrl   (we && hit[c] && (ofs == OFS_CTRL)),
      .wr_preset (we && hit[c] && (ofs == OFS_PRESET)),
      .wr_status (we && hit[c] && (ofs == OFS_STATUS)),
      .wdata     (wdata),
      .gate      (gate[c]),
      .rd_ofs    (ofs),
      .rdata     (ch_rdata[c]),
      .irq       (irq[c])
    );
  end

  // Read mux: selected channel word, the summary word, or zero for unmapped addresses.
  always_comb begin
    rdata = '0;
    for (int c = 0; c < NCH; c++) begin
      if (hit[c]) rdata = ch_rdata[c];
    end
    if (addr == ADDR_W'(SUM_WORD)) rdata[NCH-1:0] = irq;
  end

  assign irq_any = |irq;

endmodule

// File: tb/tb_tc_array.sv
module tb_tc_array;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [1:0]  gate;
  logic [1:0]  irq;
  logic        irq_any;

  int checks   = 0;
  int failures = 0;
  int cy       = 0;

  tc_array #(.NCH(2), .CNT_W(32), .ADDR_W(6)) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .we      (we),
    .wdata   (wdata),
    .rdata   (rdata),
    .gate    (gate),
    .irq     (irq),
    .irq_any (irq_any)
  );

  always #5 clk = ~clk;

  // All stimulus changes at negedge; outputs sampled at negedge.
  task automatic cyc();
    @(posedge clk);
    cy++;
    @(negedge clk);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    cy++;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    wr(6'd1, 32'd2);
    wr(6'd0, 32'h9);
    wr(6'd5, 32'd7);
    repeat (4) cyc();
    checks++;
    if (irq[0] !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_irq: got %b expected 1", irq[0]);
    end
    reset = 1'b0;
    cyc();
    checks++;
    if (irq !== 2'b00 || irq_any !== 1'b0) begin
      failures++;
      $display("FAIL reset_irq_first_edge: irq=%b any=%b expected 00/0", irq, irq_any);
    end
    cyc();
    reset = 1'b1;
    for (int a = 0; a <= 12; a++) begin
      rd(6'(a), v);
      checks++;
      if (v !== 32'd0) begin
        failures++;
        $display("FAIL reset_read addr=%0d: got %h expected 0", a, v);
      end
    end
    cyc();
    checks++;
    if (irq !== 2'b00 || irq_any !== 1'b0) begin
      failures++;
      $display("FAIL reset_irq_after: irq=%b any=%b expected 00/0", irq, irq_any);
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    wr(6'd1, 32'd5);
    wr(6'd0, 32'h9);
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) cyc();
      checks++;
      if (irq[0] !== (k >= 7) || irq_any !== (k >= 7)) begin
        failures++;
        $display("FAIL oneshot_irq k=%0d: irq0=%b any=%b expected %b", k, irq[0], irq_any, (k >= 7));
      end
    end
    rd(6'd0, v);
    checks++;
    if (v !== 32'h8) begin
      failures++;
      $display("FAIL oneshot_ctrl: got %h expected 8", v);
    end
    rd(6'd8, v);
    checks++;
    if (v !== 32'h1) begin
      failures++;
      $display("FAIL summary: got %h expected 1", v);
    end
    wr(6'd3, 32'h1);
    checks++;
    if (irq[0] !== 1'b0 || irq_any !== 1'b0) begin
      failures++;
      $display("FAIL oneshot_w1c: irq0=%b any=%b expected 0", irq[0], irq_any);
    end
  endtask

  task automatic test_autoreload();
    wr(6'd5, 32'd3);
    wr(6'd4, 32'hB);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      checks++;
      if (irq[1] !== (k >= 5)) begin
        failures++;
        $display("FAIL reload_first k=%0d: got %b expected %b", k, irq[1], (k >= 5));
      end
    end
    wr(6'd7, 32'h1);
    for (int k = 7; k <= 10; k++) begin
      if (k > 7) cyc();
      checks++;
      if (irq[1] !== (k == 10)) begin
        failures++;
        $display("FAIL reload_second k=%0d: got %b expected %b", k, irq[1], (k == 10));
      end
    end
    cyc();
    wr(6'd7, 32'h1);
    cyc();
    cyc();
    checks++;
    if (irq[1] !== 1'b0) begin
      failures++;
      $display("FAIL reload_cleared: got %b expected 0", irq[1]);
    end
    wr(6'd7, 32'h1);
    checks++;
    if (irq[1] !== 1'b1) begin
      failures++;
      $display("FAIL reload_set_wins: got %b expected 1", irq[1]);
    end
    wr(6'd4, 32'h0);
  endtask

  task automatic test_gated();
    logic [31:0] v;
    wr(6'd1, 32'd4);
    gate = 2'b01;
    wr(6'd0, 32'hD);
    cyc();
    cyc();
    cyc();
    gate = 2'b00;
    for (int k = 4; k <= 13; k++) begin
      cyc();
      rd(6'd2, v);
      checks++;
      if (v !== 32'd2 || irq[0] !== 1'b0) begin
        failures++;
        $display("FAIL gated_hold k=%0d: count=%0d irq=%b expected 2/0", k, v, irq[0]);
      end
    end
    gate = 2'b01;
    for (int k = 14; k <= 16; k++) begin
      cyc();
      checks++;
      if (irq[0] !== (k == 16)) begin
        failures++;
        $display("FAIL gated_pend k=%0d: got %b expected %b", k, irq[0], (k == 16));
      end
    end
    gate = 2'b00;
    wr(6'd0, 32'h0);
  endtask

  task automatic test_disable();
    logic [31:0] v;
    wr(6'd1, 32'd100);
    wr(6'd0, 32'h9);
    repeat (9) cyc();
    wr(6'd0, 32'h8);
    for (int k = 11; k <= 20; k++) begin
      cyc();
      rd(6'd2, v);
      checks++;
      if (v !== 32'd91 || irq[0] !== 1'b0) begin
        failures++;
        $display("FAIL disable_frozen k=%0d: count=%0d irq=%b expected 91/0", k, v, irq[0]);
      end
    end
    wr(6'd0, 32'h9);
    cyc();
    rd(6'd2, v);
    checks++;
    if (v !== 32'd100) begin
      failures++;
      $display("FAIL reenable_reload: got %0d expected 100", v);
    end
    cyc();
    rd(6'd2, v);
    checks++;
    if (v !== 32'd99) begin
      failures++;
      $display("FAIL reenable_count: got %0d expected 99", v);
    end
    wr(6'd0, 32'h0);
  endtask

  task automatic test_prescale();
    logic [31:0] v;
`ifdef TC_PRESCALE_EN
    wr(6'd1, 32'd3);
    wr(6'd0, 32'h109);
    for (int k = 1; k <= 9; k++) begin
      cyc();
      checks++;
      if (irq[0] !== (k >= 8)) begin
        failures++;
        $display("FAIL prescale k=%0d: got %b expected %b", k, irq[0], (k >= 8));
      end
    end
    rd(6'd0, v);
    checks++;
    if (v !== 32'h108) begin
      failures++;
      $display("FAIL prescale_ctrl: got %h expected 108", v);
    end
`else
    wr(6'd0, 32'h108);
    rd(6'd0, v);
    checks++;
    if (v !== 32'h8) begin
      failures++;
      $display("FAIL psc_absent: got %h expected 8", v);
    end
`endif
    wr(6'd0, 32'h0);
  endtask

  // Random one-shot presets, then both channels auto-reloading with random w1c,
  // checked against closed-form period arithmetic.
  task automatic test_random();
    logic [31:0] v, exp_cnt;
    int p [2];
    int pe [2];
    int s [2];
    bit mp [2];
    int k, q, clr_ch;
    bit clr_bit;

    for (int it = 0; it < 4; it++) begin
      p[0]  = $urandom_range(0, 15);
      pe[0] = (p[0] == 0) ? 1 : p[0];
      wr(6'd1, 32'(p[0]));
      wr(6'd0, 32'h9);
      for (int kk = 1; kk <= pe[0] + 4; kk++) begin
        cyc();
        checks++;
        if (irq[0] !== (kk >= pe[0] + 2)) begin
          failures++;
          $display("FAIL rand_oneshot P=%0d k=%0d: got %b expected %b", p[0], kk, irq[0], (kk >= pe[0] + 2));
        end
      end
      wr(6'd0, 32'h0);
    end

    for (int c = 0; c < 2; c++) begin
      p[c]  = $urandom_range(0, 12);
      pe[c] = (p[c] == 0) ? 1 : p[c];
      mp[c] = 1'b0;
      wr(6'(c * 4 + 1), 32'(p[c]));
    end
    wr(6'd0, 32'hB);
    s[0] = cy;
    wr(6'd4, 32'hB);
    s[1] = cy;
    for (int n = 0; n < 200; n++) begin
      clr_ch = -1;
      if ($urandom_range(0, 5) == 0) begin
        clr_ch  = $urandom_range(0, 1);
        clr_bit = 1'($urandom_range(0, 1));
        wr(6'(clr_ch * 4 + 3), {31'd0, clr_bit});
      end else begin
        cyc();
      end
      for (int c = 0; c < 2; c++) begin
        k = cy - s[c];
        if (k >= 1 && (k % (pe[c] + 2)) == 0) mp[c] = 1'b1;
        else if (clr_ch == c && clr_bit) mp[c] = 1'b0;
      end
      checks++;
      if (irq !== {mp[1], mp[0]} || irq_any !== (mp[0] | mp[1])) begin
        failures++;
        $display("FAIL rand_irq n=%0d: irq=%b any=%b expected %b%b", n, irq, irq_any, mp[1], mp[0]);
      end
      for (int c = 0; c < 2; c++) begin
        k = cy - s[c];
        q = (k - 1) % (pe[c] + 2);
        if (q == 0)          exp_cnt = 32'(p[c]);
        else if (q < pe[c])  exp_cnt = 32'(p[c] - q);
        else                 exp_cnt = 32'd0;
        rd(6'(c * 4 + 2), v);
        checks++;
        if (v !== exp_cnt) begin
          failures++;
          $display("FAIL rand_count ch=%0d n=%0d P=%0d: got %0d expected %0d", c, n, p[c], v, exp_cnt);
        end
      end
    end
    wr(6'd0, 32'h0);
    wr(6'd4, 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    addr  = '0;
    we    = 1'b0;
    wdata = '0;
    gate  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_oneshot();
    test_autoreload();
    test_gated();
    test_disable();
    test_prescale();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
